// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register: valid/ready handshake, flush, optional skid entry (registered in_ready).
// Latency 1 cycle when empty; 1 beat/cycle throughput; out_data/out_valid hold while stalled.
module pipe_stage_skid_reg #(
   parameter int unsigned      WIDTH       = 64,
   parameter bit               SKID        = 1'b1,
   parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic [1:0]       o_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   logic [WIDTH-1:0] r_main;
   logic             w_in_fire;
   logic             w_out_fire;

   assign w_in_fire  = i_in_valid & o_in_ready;
   assign w_out_fire = o_out_valid & i_out_ready;
   assign o_out_data = r_main;

   if (SKID) begin : g_skid
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_skid;
      logic             w_main_from_in;
      logic             w_main_from_skid;
      logic             w_skid_from_in;

      always_comb begin
         w_state_nxt      = r_state;
         w_main_from_in   = 1'b0;
         w_main_from_skid = 1'b0;
         w_skid_from_in   = 1'b0;
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt    = ST_HALF;
                  w_main_from_in = 1'b1;
               end
            end
            ST_HALF: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_from_in = 1'b1;
               end else if (w_in_fire) begin
                  w_state_nxt    = ST_FULL;
                  w_skid_from_in = 1'b1;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_state_nxt      = ST_HALF;
                  w_main_from_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end

      // Flush shares the reset path: any beat arriving that cycle is dropped too.
      always_ff @(posedge clk) begin
         if (i_rst || i_flush) begin
            r_state <= ST_EMPTY;
            r_main  <= FLUSH_VALUE;
            r_skid  <= FLUSH_VALUE;
         end else begin
            r_state <= w_state_nxt;
            if (w_main_from_in) begin
               r_main <= i_in_data;
            end else if (w_main_from_skid) begin
               r_main <= r_skid;
            end
            if (w_skid_from_in) begin
               r_skid <= i_in_data;
            end
         end
      end

      assign o_in_ready  = (r_state != ST_FULL);
      assign o_out_valid = (r_state != ST_EMPTY);
      assign o_count     = (r_state == ST_FULL) ? 2'd2 :
                           (r_state == ST_HALF) ? 2'd1 : 2'd0;
   end else begin : g_noskid
      logic r_valid;

      always_ff @(posedge clk) begin
         if (i_rst || i_flush) begin
            r_valid <= 1'b0;
            r_main  <= FLUSH_VALUE;
         end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_main  <= i_in_data;
         end else if (w_out_fire) begin
            r_valid <= 1'b0;
         end
      end

      assign o_in_ready  = !r_valid | i_out_ready;
      assign o_out_valid = r_valid;
      assign o_count     = {1'b0, r_valid};
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: SKID=1 instance (a_*) and SKID=0 instance (b_*).
module tb_pipe_stage_skid_reg;

   localparam int unsigned      W  = 16;
   localparam logic [W-1:0]     FV = 16'h0013;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic [W-1:0] a_in_data = '0;
   logic         a_in_ready, a_out_valid;
   logic [W-1:0] a_out_data;
   logic [1:0]   a_count;
   logic         b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [W-1:0] b_in_data = '0;
   logic         b_in_ready, b_out_valid;
   logic [W-1:0] b_out_data;
   logic [1:0]   b_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_skid_reg #(.WIDTH(W), .SKID(1'b1), .FLUSH_VALUE(FV)) u_a (
      .clk(clk), .i_rst(rst), .i_flush(a_flush),
      .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
      .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_data(a_out_data),
      .o_count(a_count));

   pipe_stage_skid_reg #(.WIDTH(W), .SKID(1'b0), .FLUSH_VALUE(FV)) u_b (
      .clk(clk), .i_rst(rst), .i_flush(b_flush),
      .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
      .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
      .o_count(b_count));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h0055;
      b_in_valid = 1'b1; b_in_data = 16'h0055;
      tick(); tick();
      rst = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid got %b want 0", a_out_valid); end
      n_cmp++; if (a_count !== 2'd0) begin n_err++; $display("FAIL reset_a_count got %0d want 0", a_count); end
      n_cmp++; if (a_out_data !== FV) begin n_err++; $display("FAIL reset_a_data got %h want %h", a_out_data, FV); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_in_ready got %b want 1", a_in_ready); end
      n_cmp++; if (b_out_valid !== 1'b0 || b_count !== 2'd0 || b_out_data !== FV || b_in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_b got v=%b c=%0d d=%h r=%b want 0 0 %h 1", b_out_valid, b_count, b_out_data, b_in_ready, FV);
      end
      a_in_valid = 1'b0; b_in_valid = 1'b0;
   endtask

   task automatic test_streaming();
      logic [W-1:0] exp;
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = 16'h0010 + 16'(i);
         a_in_valid = 1'b1; a_in_data = exp;
         tick();
         n_cmp++;
         if (a_out_valid !== 1'b1 || a_out_data !== exp || a_count !== 2'd1) begin
            n_err++; $display("FAIL stream_beat%0d got v=%b d=%h c=%0d want 1 %h 1", i, a_out_valid, a_out_data, a_count, exp);
         end
      end
      a_in_valid = 1'b0;
      tick();
      n_cmp++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin n_err++; $display("FAIL stream_drain got v=%b c=%0d want 0 0", a_out_valid, a_count); end
   endtask

   task automatic test_backpressure();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 16'h000A;
      tick();
      n_cmp++; if (a_count !== 2'd1 || a_in_ready !== 1'b1 || a_out_data !== 16'h000A) begin
         n_err++; $display("FAIL bp_first got c=%0d r=%b d=%h want 1 1 000a", a_count, a_in_ready, a_out_data);
      end
      a_in_data = 16'h000B;
      tick();
      n_cmp++; if (a_count !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 16'h000A) begin
         n_err++; $display("FAIL bp_full got c=%0d r=%b d=%h want 2 0 000a", a_count, a_in_ready, a_out_data);
      end
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      tick();
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h000B || a_count !== 2'd1) begin
         n_err++; $display("FAIL bp_second got v=%b d=%h c=%0d want 1 000b 1", a_out_valid, a_out_data, a_count);
      end
      tick();
      n_cmp++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin n_err++; $display("FAIL bp_empty got v=%b c=%0d want 0 0", a_out_valid, a_count); end
   endtask

   task automatic test_flush();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 16'h000C;
      tick();
      a_in_data = 16'h000D;
      tick();
      n_cmp++; if (a_count !== 2'd2) begin n_err++; $display("FAIL flush_prefill got c=%0d want 2", a_count); end
      a_flush = 1'b1; a_in_data = 16'h000E;
      tick();
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      n_cmp++; if (a_out_valid !== 1'b0 || a_count !== 2'd0 || a_out_data !== FV) begin
         n_err++; $display("FAIL flush_state got v=%b c=%0d d=%h want 0 0 %h", a_out_valid, a_count, a_out_data, FV);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_leak%0d got v=%b d=%h want v=0", i, a_out_valid, a_out_data); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp;
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_in_data = 16'h0020;
      tick();
      for (int i = 1; i <= 4; i++) begin
         exp = 16'h0020 + 16'(i);
         a_in_data = exp;
         tick();
         n_cmp++;
         if (a_count !== 2'd1 || a_out_valid !== 1'b1 || a_out_data !== exp) begin
            n_err++; $display("FAIL b2b_beat%0d got c=%0d v=%b d=%h want 1 1 %h", i, a_count, a_out_valid, a_out_data, exp);
         end
      end
      a_in_valid = 1'b0;
      tick();
      n_cmp++; if (a_count !== 2'd0) begin n_err++; $display("FAIL b2b_drain got c=%0d want 0", a_count); end
   endtask

   task automatic test_skid0();
      b_out_ready = 1'b0;
      b_in_valid = 1'b1; b_in_data = 16'h0030;
      tick();
      b_in_data = 16'h0031;
      n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_ready_low got %b want 0", b_in_ready); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (b_out_valid !== 1'b1 || b_out_data !== 16'h0030 || b_count !== 2'd1 || b_in_ready !== 1'b0) begin
            n_err++; $display("FAIL s0_hold%0d got v=%b d=%h c=%0d r=%b want 1 0030 1 0", i, b_out_valid, b_out_data, b_count, b_in_ready);
         end
      end
      b_out_ready = 1'b1;
      #1;
      n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_ready_comb got %b want 1", b_in_ready); end
      tick();
      n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h0031) begin
         n_err++; $display("FAIL s0_next got v=%b d=%h want 1 0031", b_out_valid, b_out_data);
      end
      b_in_valid = 1'b0;
      tick();
      n_cmp++; if (b_out_valid !== 1'b0 || b_count !== 2'd0) begin n_err++; $display("FAIL s0_empty got v=%b c=%0d want 0 0", b_out_valid, b_count); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_skid0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
